// File: rtl/mips_multicycle.sv
// Multicycle MIPS-lite core: FETCH/DECODE/EXEC/MEM/WB sequencer over a single
// req/ready memory port, with its own register file, ALU and next-PC logic.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       pc_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s, ir_r, a_r, b_r, alu_out_r, mdr_r;
    logic [31:0] rf_r [0:31];
    logic [5:0]  op_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, rf_waddr_s;
    logic [15:0] imm_s;
    logic [31:0] sext_s, ea_s, alu_res_s, rf_wdata_s;
    logic        decode_ok_s, is_mem_s, rf_we_s, fetch_start_s;

    assign op_s    = ir_r[31:26];
    assign rs_s    = ir_r[25:21];
    assign rt_s    = ir_r[20:16];
    assign rd_s    = ir_r[15:11];
    assign funct_s = ir_r[5:0];
    assign imm_s   = ir_r[15:0];
    assign sext_s  = {{16{imm_s[15]}}, imm_s};
    assign ea_s    = a_r + sext_s;
    assign is_mem_s = (op_s == OP_LW) || (op_s == OP_SW);
    assign pc_dbg  = pc_r;
    // Retiring transitions (beq/j, sw, WB) are the only ones that re-enter FETCH.
    assign fetch_start_s = (state_r != S_FETCH) && (state_nxt_s == S_FETCH);

    // Opcode/funct legality
    always_comb begin
        decode_ok_s = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    F_ADDU, F_SUBU, F_AND, F_OR, F_SLT: decode_ok_s = 1'b1;
                    default:                            decode_ok_s = 1'b0;
                endcase
            end
            OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: decode_ok_s = 1'b1;
            default:                                    decode_ok_s = 1'b0;
        endcase
    end

    // ALU result for register-writing instructions
    always_comb begin
        alu_res_s = 32'h0000_0000;
        case (op_s)
            OP_RTYPE: begin
                case (funct_s)
                    F_ADDU:  alu_res_s = a_r + b_r;
                    F_SUBU:  alu_res_s = a_r - b_r;
                    F_AND:   alu_res_s = a_r & b_r;
                    F_OR:    alu_res_s = a_r | b_r;
                    F_SLT:   alu_res_s = ($signed(a_r) < $signed(b_r)) ? 32'd1 : 32'd0;
                    default: alu_res_s = 32'h0000_0000;
                endcase
            end
            OP_ORI:  alu_res_s = a_r | {16'h0000, imm_s};
            OP_LUI:  alu_res_s = {imm_s, 16'h0000};
            default: alu_res_s = 32'h0000_0000;
        endcase
    end

    // Next state and next PC
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        case (state_r)
            S_FETCH: begin
                if (mem_req && mem_ready) begin
                    state_nxt_s = S_DECODE;
                    pc_nxt_s    = pc_r + 32'd4;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: state_nxt_s = decode_ok_s ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (is_mem_s) begin
                    state_nxt_s = (ea_s[1:0] != 2'b00) ? S_HALT : S_MEM;
                end else if (op_s == OP_BEQ) begin
                    state_nxt_s = S_FETCH;
                    if (a_r == b_r) begin
                        pc_nxt_s = pc_r + {sext_s[29:0], 2'b00};
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end else if (op_s == OP_J) begin
                    state_nxt_s = S_FETCH;
                    pc_nxt_s    = {pc_r[31:28], ir_r[25:0], 2'b00};
                end else begin
                    state_nxt_s = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_nxt_s = (op_s == OP_LW) ? S_WB : S_FETCH;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB:    state_nxt_s = S_FETCH;
            S_HALT:  state_nxt_s = S_HALT;
            default: state_nxt_s = S_HALT;
        endcase
    end

    // Register-file write port selection
    always_comb begin
        rf_we_s    = (state_r == S_WB);
        rf_waddr_s = (op_s == OP_RTYPE) ? rd_s : rt_s;
        rf_wdata_s = (op_s == OP_LW) ? mdr_r : alu_out_r;
    end

    // Sequencer, architectural latches and registered memory-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_FETCH;
            pc_r      <= RESET_PC;
            ir_r      <= 32'h0000_0000;
            a_r       <= 32'h0000_0000;
            b_r       <= 32'h0000_0000;
            alu_out_r <= 32'h0000_0000;
            mdr_r     <= 32'h0000_0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            retire    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            retire  <= 1'b0;
            halted  <= (state_nxt_s == S_HALT);
            case (state_r)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_r[ADDR_W-1:0];
                    end else if (mem_ready) begin
                        mem_req <= 1'b0;
                        ir_r    <= mem_rdata;
                    end
                end
                S_DECODE: begin
                    a_r <= (rs_s == 5'd0) ? 32'h0000_0000 : rf_r[rs_s];
                    b_r <= (rt_s == 5'd0) ? 32'h0000_0000 : rf_r[rt_s];
                end
                S_EXEC: begin
                    alu_out_r <= is_mem_s ? ea_s : alu_res_s;
                    if (state_nxt_s == S_MEM) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (op_s == OP_SW);
                        mem_addr  <= ea_s[ADDR_W-1:0];
                        mem_wdata <= b_r;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mdr_r   <= mem_rdata;
                    end
                end
                default: begin
                    mem_req <= mem_req;
                end
            endcase
            // Starting the next fetch overrides the completion's deassertion.
            if (fetch_start_s) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= pc_nxt_s[ADDR_W-1:0];
                retire   <= 1'b1;
            end
            if (state_nxt_s == S_HALT) begin
                mem_req <= 1'b0;
            end
        end
    end

    // Register file; contents survive reset, $0 is never written
    always_ff @(posedge clk) begin
        if (rf_we_s && (rf_waddr_s != 5'd0)) begin
            rf_r[rf_waddr_s] <= rf_wdata_s;
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: wait-state memory responder, instruction-level
// reference model, per-retire compare process and directed programs.
module tb_mips_multicycle;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk, rst;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

    mips_multicycle #(.RESET_PC(RESET_PC), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .retire(retire), .halted(halted), .pc_dbg(pc_dbg)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] mregs   [32];
    logic [31:0] mpc;
    logic [31:0] exp_pc[$];
    int          exp_gap[$];
    bit          exp_halt;
    bit          chk_en;
    int          wait_states;
    bit          idle_ready;
    int          n_req;
    int          cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[31:2]]     = w;
        ref_mem[addr[31:2]] = w;
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] addr);
        return mem.exists(addr[31:2]) ? mem[addr[31:2]] : 32'h0000_0000;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] addr);
        return ref_mem.exists(addr[31:2]) ? ref_mem[addr[31:2]] : 32'h0000_0000;
    endfunction

    // Instruction-level reference: executes one instruction, reports latency.
    task automatic model_step(output bit h, output int lat);
        logic [31:0] ins, a, b, se, ze, ea, npc;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        ins = rd_ref(mpc);
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        a = mregs[rs]; b = mregs[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        npc = mpc + 32'd4;
        h = 1'b0;
        lat = 0;
        case (op)
            6'h00: begin
                lat = 4 + wait_states;
                case (fn)
                    6'h21:   mregs[rd] = a + b;
                    6'h23:   mregs[rd] = a - b;
                    6'h24:   mregs[rd] = a & b;
                    6'h25:   mregs[rd] = a | b;
                    6'h2A:   mregs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: h = 1'b1;
                endcase
            end
            6'h0D: begin lat = 4 + wait_states; mregs[rt] = a | ze; end
            6'h0F: begin lat = 4 + wait_states; mregs[rt] = {ins[15:0], 16'h0000}; end
            6'h23: begin
                ea = a + se;
                if (ea[1:0] != 2'b00) h = 1'b1;
                else begin mregs[rt] = rd_ref(ea); lat = 5 + 2 * wait_states; end
            end
            6'h2B: begin
                ea = a + se;
                if (ea[1:0] != 2'b00) h = 1'b1;
                else begin ref_mem[ea[31:2]] = b; lat = 4 + 2 * wait_states; end
            end
            6'h04: begin lat = 3 + wait_states; if (a == b) npc = npc + (se << 2); end
            6'h02: begin lat = 3 + wait_states; npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: h = 1'b1;
        endcase
        mregs[0] = 32'h0000_0000;
        if (!h) mpc = npc;
    endtask

    // Memory responder: fixed wait states per access, checks request stability
    initial begin
        bit busy, done;
        int wcnt;
        logic [31:0] cap_addr, cap_wd;
        logic cap_we;
        busy = 1'b0; done = 1'b0; wcnt = 0;
        cap_addr = 32'h0; cap_wd = 32'h0; cap_we = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0; done = 1'b0; mem_ready = 1'b0;
            end else begin
                if (done) begin busy = 1'b0; done = 1'b0; end
                if (mem_req) begin
                    if (!busy) begin
                        busy = 1'b1; wcnt = 0; n_req++;
                        cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
                    end else begin
                        chk("hold_addr", mem_addr, cap_addr);
                        chk("hold_we", {31'd0, mem_we}, {31'd0, cap_we});
                        if (cap_we) chk("hold_wdata", mem_wdata, cap_wd);
                    end
                    if (wcnt == wait_states) begin
                        mem_ready = 1'b1;
                        if (cap_we) mem[cap_addr[31:2]] = cap_wd;
                        else mem_rdata = rd_word(cap_addr);
                        done = 1'b1;
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = 32'hDEAD_BEEF;
                        wcnt++;
                    end
                end else begin
                    mem_ready = idle_ready;
                    mem_rdata = 32'hBAD0_C0DE;
                end
            end
        end
    end

    // Compare process: every retire against the model's pc and cycle count
    always @(negedge clk) begin
        if (!chk_en) begin
            cyc = 0;
        end else begin
            cyc++;
            if (retire) begin
                if (exp_pc.size() == 0) begin
                    chk("extra_retire", 32'd1, 32'd0);
                end else begin
                    chk("retire_pc", pc_dbg, exp_pc.pop_front());
                    chk("retire_gap", cyc, exp_gap.pop_front());
                end
                cyc = 0;
            end
            if (halted) begin
                chk("halt_no_req", {31'd0, mem_req}, 32'd0);
                chk("halt_expected", {31'd0, exp_halt && (exp_pc.size() == 0)}, 32'd1);
            end
        end
    end

    task automatic run_prog(input int waits, input bit idle_rdy, input int n_instr,
                            input int budget, output int stop_c);
        bit h, ok;
        int lat;
        chk_en = 1'b0; rst = 1'b1;
        wait_states = waits; idle_ready = idle_rdy;
        mpc = RESET_PC; exp_pc.delete(); exp_gap.delete(); exp_halt = 1'b0;
        for (int k = 0; k < n_instr; k++) begin
            model_step(h, lat);
            if (h) begin exp_halt = 1'b1; break; end
            exp_pc.push_back(mpc);
            exp_gap.push_back(lat + ((k == 0) ? 1 : 0));
        end
        @(negedge clk); #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_pc", pc_dbg, RESET_PC);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        #1;
        n_req = 0; rst = 1'b0; chk_en = 1'b1;
        @(posedge clk); #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, RESET_PC);
        ok = 1'b0; stop_c = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (exp_pc.size() == 0 && (!exp_halt || halted)) begin ok = 1'b1; stop_c = c; break; end
        end
        chk("run_complete", {31'd0, ok}, 32'd1);
        if (exp_halt) repeat (6) @(negedge clk);
        #1 chk_en = 1'b0;
    endtask

    initial begin
        int sc;
        bit found;
        rst = 1'b1; chk_en = 1'b0; wait_states = 0; idle_ready = 1'b0; n_req = 0; cyc = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0000_0000;

        // ALU program, zero wait, ready held high while idle
        mem.delete(); ref_mem.delete();
        put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'd5));
        put(32'h3004, enc_i(6'h0D, 5'd0, 5'd2, 16'd7));
        put(32'h3008, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
        put(32'h300C, enc_r(5'd1, 5'd2, 5'd6, 6'h23));
        put(32'h3010, enc_r(5'd6, 5'd1, 5'd7, 6'h2A));
        put(32'h3014, enc_r(5'd1, 5'd2, 5'd8, 6'h24));
        put(32'h3018, enc_r(5'd1, 5'd2, 5'd9, 6'h25));
        put(32'h301C, enc_i(6'h04, 5'd1, 5'd2, 16'd5));
        run_prog(0, 1'b1, 10, 200, sc);
        chk("model_r3", mregs[3], 32'd12);
        chk("r3_addu", dut.rf_r[3], 32'd12);
        chk("r6_subu", dut.rf_r[6], 32'hFFFF_FFFE);
        chk("r7_slt", dut.rf_r[7], 32'd1);
        chk("r8_and", dut.rf_r[8], 32'd5);
        chk("r9_or", dut.rf_r[9], 32'd7);
        chk("halt_pc", pc_dbg, 32'h0000_3024);

        // Store/load round trip, two wait states per access
        mem.delete(); ref_mem.delete();
        put(32'h3000, enc_i(6'h0F, 5'd0, 5'd4, 16'h1234));
        put(32'h3004, enc_i(6'h0D, 5'd4, 5'd4, 16'h5678));
        put(32'h3008, enc_i(6'h2B, 5'd0, 5'd4, 16'h0010));
        put(32'h300C, enc_i(6'h23, 5'd0, 5'd5, 16'h0010));
        run_prog(2, 1'b0, 5, 200, sc);
        chk("model_r5", mregs[5], 32'h1234_5678);
        chk("r5_lw", dut.rf_r[5], 32'h1234_5678);
        chk("mem_sw", rd_word(32'h10), 32'h1234_5678);

        // beq $0,$0,-1 spinning at the reset vector
        mem.delete(); ref_mem.delete();
        put(32'h3000, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
        run_prog(0, 1'b0, 4, 100, sc);
        chk("model_beq_pc", mpc, 32'h0000_3000);

        // ori then j 0x0C00 back to 0x3000, one wait state
        mem.delete(); ref_mem.delete();
        put(32'h3000, enc_i(6'h0D, 5'd0, 5'd1, 16'd1));
        put(32'h3004, {6'h02, 26'h000_0C00});
        run_prog(1, 1'b0, 4, 100, sc);
        chk("model_j_pc", mpc, 32'h0000_3000);

        // Undefined opcode halts straight after DECODE
        mem.delete(); ref_mem.delete();
        put(32'h3000, 32'hFC00_0000);
        run_prog(0, 1'b0, 2, 40, sc);
        chk("undef_halt_cycle", sc, 32'd2);
        chk("undef_req_count", n_req, 32'd1);

        // Misaligned lw halts in EXEC with no data access
        mem.delete(); ref_mem.delete();
        put(32'h3000, enc_i(6'h23, 5'd0, 5'd5, 16'h0011));
        run_prog(0, 1'b0, 2, 40, sc);
        chk("misalign_halt_cycle", sc, 32'd3);
        chk("misalign_req_count", n_req, 32'd1);

        // Reset asserted while lw is stalled in its data access
        mem.delete(); ref_mem.delete();
        put(32'h3000, enc_i(6'h23, 5'd0, 5'd5, 16'h0010));
        wait_states = 3; idle_ready = 1'b0; chk_en = 1'b0;
        rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (mem_req && !mem_we && mem_addr == 32'h10) begin found = 1'b1; break; end
        end
        chk("mid_stall_seen", {31'd0, found}, 32'd1);
        @(negedge clk); #2;
        chk("mid_still_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_drop", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_pc", pc_dbg, RESET_PC);
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("refetch_req", {31'd0, mem_req}, 32'd1);
        chk("refetch_addr", mem_addr, RESET_PC);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
